store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Store path from the MEM stage to the data-SRAM-like bus. It pairs with the WB-stage load extraction.
//  - Aligns store data and generates byte-selects in the same BSEL encoding the load path decodes:
//    bit3 = lane bits 7:0, bit0 = lane bits 31:24.
//  - Queues committed stores in a DEPTH-entry FIFO and drains them one at a time over a req/addr_ok/data_ok handshake.
//  - Flags a load hazard when a younger load hits a pending store word.
// PARAMETERS
//  SB_DEPTH  4               FIFO entries; power of two, >= 2
//  SB_AW     $clog2(SB_DEPTH) FIFO pointer width
// PORTS
//  cpu_clk_50M    in   1   clock; all state updates on the rising edge
//  cpu_rst_n      in   1   reset, synchronous, active-low
//  st_req_i       in   1   committed store from MEM stage is valid this cycle
//  st_addr_i      in   32  store byte address; alignment is pre-checked upstream
//  st_size_i      in   2   00 = byte, 01 = half, 10 = word; 11 is treated as word
//  st_data_i      in   32  unaligned source data; the value sits in the low bits
//  st_accept_o    out  1   the store is written into the FIFO at this edge
//  ld_req_i       in   1   MEM stage is issuing a load
//  ld_addr_i      in   32  load byte address
//  ld_hazard_o    out  1   a valid entry matches ld_addr_i[31:2]
//  stallreq_o     out  1   pipeline stall request: (st_req_i & full) | ld_hazard_o
//  sb_empty_o     out  1   FIFO empty and no bus transaction outstanding
//  data_req_o     out  1   bus request; held until data_addr_ok_i
//  data_wr_o      out  1   constant 1 while data_req_o is high
//  data_size_o    out  2   size of the head entry
//  data_addr_o    out  32  address of the head entry
//  data_wstrb_o   out  4   head BSEL bit-reversed (bit0 = lane 7:0)
//  data_wdata_o   out  32  aligned data of the head entry
//  data_addr_ok_i in   1   request accepted
//  data_data_ok_i in   1   write completed
// BEHAVIOUR
//  Alignment (combinational, applied on push):
//   - byte: bsel = 4'b1000 >> addr[1:0]; wdata = {4{data[7:0]}}
//   - half: bsel = addr[1] ? 4'b0011 : 4'b1100; wdata = {2{data[15:0]}}
//   - word: bsel = 4'b1111; wdata = data
//  Push: st_accept_o = st_req_i & (count < SB_DEPTH), evaluated at cycle start. There is no same-cycle pop bypass.
//  Pop: the head is removed on the cycle data_data_ok_i is seen in WAIT. Push and pop in the same cycle leave count unchanged.
//  Drain FSM states IDLE, REQ, WAIT:
//   - IDLE -> REQ when count != 0.
//   - REQ: data_req_o = 1. REQ -> WAIT on data_addr_ok_i. If data_data_ok_i arrives in the same cycle, pop and go to REQ when count > 1, else IDLE.
//   - WAIT: data_req_o = 0. On data_data_ok_i, pop and go to REQ when count > 1, else IDLE.
//   - Only one transaction is outstanding. data_data_ok_i outside WAIT/REQ is ignored.
//  Bus signals come directly from the head registers and stay stable while data_req_o is high.
//  Hazard: ld_hazard_o = ld_req_i & OR over valid entries of (entry.addr[31:2] == ld_addr_i[31:2]).
//   - It is combinational and includes the in-flight head.
//   - It excludes the store being pushed this cycle; the MEM stage orders that store itself.
//  Full: st_req_i while full gives st_accept_o = 0 and stallreq_o = 1. The MEM stage holds the request.
//  Reset (any cycle, including mid-transaction):
//   - Pointers and count go to 0 and the FSM goes to IDLE.
//   - Outputs: data_req_o, st_accept_o, ld_hazard_o and stallreq_o are 0; sb_empty_o is 1; data_* buses are 0.
//   - A late data_data_ok_i from an aborted transaction is dropped.
//  Wrap-around: pointers are SB_AW bits and wrap naturally. count is SB_AW+1 bits.
// STRUCTURE
//  defines.v additions:
//   - `SIZE_BYTE/`SIZE_HALF/`SIZE_WORD
//   - `SB_IDLE/`SB_REQ/`SB_WAIT state codes
//   - existing `BSEL_BUS is reused
//  Sub-module store_align: combinational size/addr/data -> bsel/wdata. The bench reuses its encoding as the golden model.
//  store_buffer holds the FIFO register arrays, pointers, count, the FSM and the hazard compare.
// TESTING
//  1. sb 0x00000003 data 0x000000AB -> one bus req, addr 0x03, wstrb 4'b1000, wdata 0xABABABAB, sb_empty_o 1 after data_ok.
//  2. sh 0x00000006 data 0x1234 -> internal bsel 4'b0011, wstrb 4'b1100, wdata 0x12341234; sw 0x08 -> wstrb 4'b1111.
//  3. Hold addr_ok low, push 5 stores -> 4 accepted, 5th stallreq_o 1 until first data_ok, then accepted; drain order FIFO.
//  4. Pending sw 0x100 with ld_req_i at 0x102 -> ld_hazard_o 1; load at 0x104 -> 0; after drain 0x102 -> 0.
//  5. addr_ok and data_ok in the same cycle with 2 entries -> back-to-back reqs with no IDLE cycle; count 2 -> 0 in 2 transactions.
//  6. Reset in WAIT with 3 entries, then a stray data_ok -> FIFO empty, data_req_o 0, no pop and no bus activity afterwards.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// ============================================================================
// store_buffer_pkg : size codes, drain states and FIFO entry layout
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package store_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_t;

  // BSEL: bit3 = lane bits 7:0, bit0 = lane bits 31:24 (load path encoding)
  typedef logic [3:0] bsel_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    bsel_t       bsel;
    logic [31:0] wdata;
  } sb_entry_t;

  function automatic logic [3:0] bsel_to_wstrb(input bsel_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// store_buffer_if : MEM-stage store/load side plus data-SRAM bus of the buffer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface store_buffer_if;
  import store_buffer_pkg::*;

  logic        st_req_i;
  logic [31:0] st_addr_i;
  logic [1:0]  st_size_i;
  logic [31:0] st_data_i;
  logic        st_accept_o;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_hazard_o;
  logic        stallreq_o;
  logic        sb_empty_o;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  bsel_t       data_wstrb_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;

  // master: the store buffer itself (it masters the data bus)
  modport master (
    input  st_req_i, st_addr_i, st_size_i, st_data_i,
    input  ld_req_i, ld_addr_i,
    input  data_addr_ok_i, data_data_ok_i,
    output st_accept_o, ld_hazard_o, stallreq_o, sb_empty_o,
    output data_req_o, data_wr_o, data_size_o, data_addr_o,
    output data_wstrb_o, data_wdata_o
  );

  modport slave (
    output st_req_i, st_addr_i, st_size_i, st_data_i,
    output ld_req_i, ld_addr_i,
    output data_addr_ok_i, data_data_ok_i,
    input  st_accept_o, ld_hazard_o, stallreq_o, sb_empty_o,
    input  data_req_o, data_wr_o, data_size_o, data_addr_o,
    input  data_wstrb_o, data_wdata_o
  );

endinterface

`default_nettype wire

// File: rtl/store_buffer_align.sv
// ============================================================================
// store_buffer_align : store size/address/data -> byte selects and lane data
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module store_buffer_align
  import store_buffer_pkg::*;
(
  input  wire logic [1:0]  i_size,
  input  wire logic [1:0]  i_addr_lo,
  input  wire logic [31:0] i_data,
  output bsel_t            o_bsel,
  output logic      [31:0] o_wdata
);

  always_comb begin
    o_bsel  = 4'b1111;
    o_wdata = i_data;
    case (i_size)
      SIZE_BYTE: begin
        o_bsel  = 4'b1000 >> i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      SIZE_HALF: begin
        o_bsel  = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_data[15:0]}};
      end
      default: begin
        o_bsel  = 4'b1111;
        o_wdata = i_data;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : committed-store FIFO draining over req/addr_ok/data_ok,
//                with load-hazard detection against pending store words
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned SB_AW    = $clog2(SB_DEPTH)
) (
  input  wire logic       cpu_clk_50M,
  input  wire logic       cpu_rst_n,
  store_buffer_if.master  sb
);

  localparam logic [SB_AW:0] c_DEPTH = SB_DEPTH[SB_AW:0];
  localparam logic [SB_AW:0] c_ONE   = {{SB_AW{1'b0}}, 1'b1};

  sb_entry_t          r_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_vld;
  logic [SB_AW-1:0]   r_wp;
  logic [SB_AW-1:0]   r_rp;
  logic [SB_AW:0]     r_count;
  sb_state_t          r_state;
  logic               r_req;

  bsel_t              w_bsel;
  logic [31:0]        w_wdata;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_more;
  logic               w_hazard;
  logic [SB_DEPTH-1:0] w_hit;
  sb_entry_t          w_head;
  logic [1:0]         w_unused_ld_lo;

  store_buffer_align u_align (
    .i_size    (sb.st_size_i),
    .i_addr_lo (sb.st_addr_i[1:0]),
    .i_data    (sb.st_data_i),
    .o_bsel    (w_bsel),
    .o_wdata   (w_wdata)
  );

  assign w_full = (r_count == c_DEPTH);
  assign w_push = cpu_rst_n & sb.st_req_i & ~w_full;
  // A pop needs the request accepted: data_ok alone in REQ is not a completion
  assign w_pop  = cpu_rst_n & sb.data_data_ok_i &
                  (((r_state == SB_REQ) & sb.data_addr_ok_i) | (r_state == SB_WAIT));
  assign w_more = (r_count > c_ONE);
  assign w_head = r_mem[r_rp];

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= '{addr: sb.st_addr_i, size: sb.st_size_i,
                         bsel: w_bsel, wdata: w_wdata};
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      r_state <= SB_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (r_count != '0) begin
            r_state <= SB_REQ;
            r_req   <= 1'b1;
          end
        end
        SB_REQ: begin
          if (sb.data_addr_ok_i) begin
            if (sb.data_data_ok_i) begin
              r_state <= w_more ? SB_REQ : SB_IDLE;
              r_req   <= w_more;
            end else begin
              r_state <= SB_WAIT;
              r_req   <= 1'b0;
            end
          end
        end
        SB_WAIT: begin
          if (sb.data_data_ok_i) begin
            r_state <= w_more ? SB_REQ : SB_IDLE;
            r_req   <= w_more;
          end
        end
        default: begin
          r_state <= SB_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_hazard
    assign w_hit[gi] = r_vld[gi] & (r_mem[gi].addr[31:2] == sb.ld_addr_i[31:2]);
  end

  assign w_unused_ld_lo = sb.ld_addr_i[1:0];
  assign w_hazard       = cpu_rst_n & sb.ld_req_i & (|w_hit);

  assign sb.st_accept_o  = w_push;
  assign sb.ld_hazard_o  = w_hazard;
  assign sb.stallreq_o   = cpu_rst_n & ((sb.st_req_i & w_full) | w_hazard);
  assign sb.sb_empty_o   = ~cpu_rst_n | (r_count == '0);
  assign sb.data_req_o   = cpu_rst_n & r_req;
  assign sb.data_wr_o    = cpu_rst_n & r_req;
  assign sb.data_size_o  = cpu_rst_n ? w_head.size  : 2'b00;
  assign sb.data_addr_o  = cpu_rst_n ? w_head.addr  : 32'h0;
  assign sb.data_wstrb_o = cpu_rst_n ? bsel_to_wstrb(w_head.bsel) : 4'h0;
  assign sb.data_wdata_o = cpu_rst_n ? w_head.wdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : random stores/loads/bus handshakes against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } st_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer #(.SB_DEPTH(4)) u_dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .sb          (sb_if)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Strobe bit n enables byte lane n (bits 8n+7:8n)
  function automatic logic [3:0] ref_wstrb(input st_t e);
    if (e.size == 2'b00) return 4'b0001 << e.addr[1:0];
    if (e.size == 2'b01) return e.addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input st_t e);
    if (e.size == 2'b00) return {4{e.data[7:0]}};
    if (e.size == 2'b01) return {2{e.data[15:0]}};
    return e.data;
  endfunction

  function automatic logic [31:0] pool_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h8000_0100 : 32'h0000_0100;
    return base + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  st_t q[$];
  st_t cur;
  bit  pend, exp_req, hold, exp_acc, hz, pop, nreq;
  int  ok_pct, st_pct;

  initial begin
    sb_if.st_req_i       = 1'b0;
    sb_if.st_addr_i      = '0;
    sb_if.st_size_i      = '0;
    sb_if.st_data_i      = '0;
    sb_if.ld_req_i       = 1'b0;
    sb_if.ld_addr_i      = '0;
    sb_if.data_addr_ok_i = 1'b0;
    sb_if.data_data_ok_i = 1'b0;
    pend = 0; exp_req = 0; hold = 0;
    ok_pct = 50; st_pct = 70;
    cur = '{addr: 32'h0, size: 2'b00, data: 32'h0};

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       ok_pct = 5;
          1:       ok_pct = 50;
          default: ok_pct = 95;
        endcase
        st_pct = 30 + 30 * int'($urandom_range(0, 2));
      end
      rst_n = !(cyc < 3 || $urandom_range(0, 249) == 0);

      if (!hold) begin
        cur.size = 2'($urandom_range(0, 3));
        cur.data = $urandom;
        cur.addr = pool_addr();
        if (cur.size == 2'b00) cur.addr = cur.addr + 32'($urandom_range(0, 3));
        else if (cur.size == 2'b01) cur.addr = cur.addr + 32'($urandom_range(0, 1)) * 32'd2;
        sb_if.st_req_i = ($urandom_range(0, 99) < st_pct);
      end
      sb_if.st_addr_i = cur.addr;
      sb_if.st_size_i = cur.size;
      sb_if.st_data_i = cur.data;

      sb_if.ld_req_i  = $urandom_range(0, 1) == 1;
      sb_if.ld_addr_i = pool_addr() + 32'($urandom_range(0, 3));

      sb_if.data_addr_ok_i = ($urandom_range(0, 99) < ok_pct);
      if (pend)
        sb_if.data_data_ok_i = ($urandom_range(0, 99) < ok_pct);
      else if (exp_req)
        sb_if.data_data_ok_i = sb_if.data_addr_ok_i & ($urandom_range(0, 1) == 1);
      else
        sb_if.data_data_ok_i = ($urandom_range(0, 7) == 0);

      @(negedge clk);
      if (!rst_n) begin
        chk("rst_accept", 32'(sb_if.st_accept_o), 32'd0);
        chk("rst_hazard", 32'(sb_if.ld_hazard_o), 32'd0);
        chk("rst_stall",  32'(sb_if.stallreq_o),  32'd0);
        chk("rst_empty",  32'(sb_if.sb_empty_o),  32'd1);
        chk("rst_req",    32'(sb_if.data_req_o),  32'd0);
        chk("rst_addr",   sb_if.data_addr_o,      32'd0);
        chk("rst_wstrb",  32'(sb_if.data_wstrb_o), 32'd0);
        chk("rst_wdata",  sb_if.data_wdata_o,     32'd0);
        chk("rst_size",   32'(sb_if.data_size_o), 32'd0);
        q.delete();
        pend = 0; exp_req = 0; hold = 0;
        continue;
      end

      exp_acc = sb_if.st_req_i && (q.size() < 4);
      hz = 0;
      if (sb_if.ld_req_i)
        foreach (q[i]) if (q[i].addr[31:2] == sb_if.ld_addr_i[31:2]) hz = 1;

      chk("accept", 32'(sb_if.st_accept_o), 32'(exp_acc));
      chk("hazard", 32'(sb_if.ld_hazard_o), 32'(hz));
      chk("stall",  32'(sb_if.stallreq_o),  32'((sb_if.st_req_i && q.size() == 4) || hz));
      chk("empty",  32'(sb_if.sb_empty_o),  32'(q.size() == 0));
      chk("req",    32'(sb_if.data_req_o),  32'(exp_req));
      if (exp_req && q.size() > 0) begin
        chk("wr",    32'(sb_if.data_wr_o),    32'd1);
        chk("addr",  sb_if.data_addr_o,       q[0].addr);
        chk("size",  32'(sb_if.data_size_o),  32'(q[0].size));
        chk("wstrb", 32'(sb_if.data_wstrb_o), 32'(ref_wstrb(q[0])));
        chk("wdata", sb_if.data_wdata_o,      ref_wdata(q[0]));
      end

      // Expected state after this edge, from the handshake rules
      pop = (exp_req && sb_if.data_addr_ok_i && sb_if.data_data_ok_i) ||
            (pend && sb_if.data_data_ok_i);
      if (pop)                               nreq = (q.size() > 1);
      else if (exp_req)                      nreq = !sb_if.data_addr_ok_i;
      else if (pend)                         nreq = 0;
      else                                   nreq = (q.size() != 0);
      if (pend) pend = !sb_if.data_data_ok_i;
      else      pend = exp_req && sb_if.data_addr_ok_i && !sb_if.data_data_ok_i;
      exp_req = nreq;
      if (pop) void'(q.pop_front());
      if (exp_acc) q.push_back(cur);
      hold = sb_if.st_req_i && !exp_acc;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
